period_meter: RTL

- Inverse of the clock divider: measures an incoming slow periodic signal (a divided clock or tick, or an external square wave) in `clk_in` ticks.
- Synchronises the input, detects rising edges, and counts cycles between successive rising edges (period) and cycles spent high (high time).
- Presents each measurement with a one-cycle valid pulse, and flags loss of signal by timeout.
- Used for self-check of divider outputs and for frequency or duty sanity monitors in the game logic.

---
 rtl/period_meter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous input in clk_in ticks,
// with a one-cycle valid pulse per measurement and a sticky loss-of-signal timeout.
module period_meter #(
  parameter  int unsigned CLK_IN_FREQ_HZ = 100_000_000,
  parameter  int unsigned MIN_FREQ_HZ    = 100,
  parameter  int unsigned SYNC_STAGES    = 2,
  localparam int unsigned TIMEOUT_TICKS  = CLK_IN_FREQ_HZ / MIN_FREQ_HZ,
  localparam int unsigned COUNT_W        = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] period_ticks,
  output logic [COUNT_W-1:0] high_ticks,
  output logic               meas_valid,
  output logic               locked,
  output logic               timeout
);

  typedef enum logic {
    ST_WAIT_FIRST = 1'b0,
    ST_MEASURE    = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(TIMEOUT_TICKS);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  state_t                 r_state;
  logic [COUNT_W-1:0]     r_cnt;
  logic [COUNT_W-1:0]     r_hcnt;
  logic [COUNT_W-1:0]     r_period;
  logic [COUNT_W-1:0]     r_high;
  logic                   r_valid;
  logic                   r_locked;
  logic                   r_timeout;

  logic                   w_sig_s;
  logic                   w_rise;
  state_t                 w_state_nxt;
  logic [COUNT_W-1:0]     w_cnt_nxt;
  logic [COUNT_W-1:0]     w_hcnt_nxt;
  logic [COUNT_W-1:0]     w_period_nxt;
  logic [COUNT_W-1:0]     w_high_nxt;
  logic                   w_valid_nxt;
  logic                   w_locked_nxt;
  logic                   w_timeout_nxt;

  // Input synchroniser and rising-edge detect
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= w_sig_s;
    end
  end

  assign w_sig_s = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_sig_s & ~r_prev;

  // State, counters and registered outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state   <= ST_WAIT_FIRST;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // A rise takes priority over the timeout when both land in the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hcnt_nxt    = r_hcnt;
    w_period_nxt  = r_period;
    w_high_nxt    = r_high;
    w_valid_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;

    if (w_rise) begin
      w_cnt_nxt   = CNT_ONE;
      w_hcnt_nxt  = CNT_ONE;
      w_state_nxt = ST_MEASURE;
      case (r_state)
        ST_MEASURE: begin
          w_period_nxt  = r_cnt;
          w_high_nxt    = r_hcnt;
          w_valid_nxt   = 1'b1;
          w_locked_nxt  = 1'b1;
          w_timeout_nxt = 1'b0;
        end
        default: ;
      endcase
    end else if (r_cnt == CNT_MAX) begin
      w_timeout_nxt = 1'b1;
      w_locked_nxt  = 1'b0;
      w_cnt_nxt     = '0;
      w_hcnt_nxt    = '0;
      w_state_nxt   = ST_WAIT_FIRST;
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
      case (r_state)
        ST_MEASURE: w_hcnt_nxt = r_hcnt + COUNT_W'(w_sig_s);
        default:    w_hcnt_nxt = '0;
      endcase
    end
  end

  assign period_ticks = r_period;
  assign high_ticks   = r_high;
  assign meas_valid   = r_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule
